// File: rtl/cache_bus_pkg.sv
// Shared types and helpers for the cache line-fill / write-back AXI engine.
package cache_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrData,
    StWrResp,
    StDone
  } bus_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Number of byte-offset bits inside one cache line.
  function automatic int unsigned line_offset_bits(input int unsigned line_words,
                                                   input int unsigned data_width);
    return $clog2(line_words * data_width / 8);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
module rr_arbiter #(
  parameter int unsigned NUM_CLIENTS = 2,
  localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic                   grant_en_i,
  output logic [NUM_CLIENTS-1:0] grant_o,
  output logic [IdxW-1:0]        grant_idx_o,
  output logic                   grant_valid_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    for (int unsigned i = 1; i <= NUM_CLIENTS; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NUM_CLIENTS);
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
    end
    if (grant_valid_o) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

  // Reset pointer at the last client so client 0 wins the first contest.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IdxW'(NUM_CLIENTS - 1);
    end else if (grant_en_i && grant_valid_o) begin
      ptr_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// N-client cache line-fill / write-back engine on an AXI master port,
// with snoop forwarding as invalidate pulses and stale-fill re-invalidation.
module cache_axi_arbiter
  import cache_bus_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned ID_WIDTH    = 13,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned LINE_WORDS  = 16,
  localparam int unsigned LINE_BITS  = LINE_WORDS * DATA_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_CLIENTS-1:0]            command_valid_i,
  input  logic [NUM_CLIENTS-1:0]            command_store_i,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] command_addr_i,
  input  logic [NUM_CLIENTS*LINE_BITS-1:0]  data_in_i,
  output logic [NUM_CLIENTS-1:0]            bus_valid_o,
  output logic [LINE_BITS-1:0]              data_out_o,
  output logic                              invalidate_o,
  output logic [ADDR_WIDTH-1:0]             invalidate_addr_o,
  output logic [ID_WIDTH-1:0]               m_axi_arid_o,
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr_o,
  output logic [7:0]                        m_axi_arlen_o,
  output logic [2:0]                        m_axi_arsize_o,
  output logic [1:0]                        m_axi_arburst_o,
  output logic                              m_axi_arlock_o,
  output logic [3:0]                        m_axi_arcache_o,
  output logic [2:0]                        m_axi_arprot_o,
  output logic                              m_axi_arvalid_o,
  input  logic                              m_axi_arready_i,
  input  logic [ID_WIDTH-1:0]               m_axi_rid_i,
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata_i,
  input  logic [1:0]                        m_axi_rresp_i,
  input  logic                              m_axi_rlast_i,
  input  logic                              m_axi_rvalid_i,
  output logic                              m_axi_rready_o,
  output logic [ID_WIDTH-1:0]               m_axi_awid_o,
  output logic [ADDR_WIDTH-1:0]             m_axi_awaddr_o,
  output logic [7:0]                        m_axi_awlen_o,
  output logic [2:0]                        m_axi_awsize_o,
  output logic [1:0]                        m_axi_awburst_o,
  output logic                              m_axi_awlock_o,
  output logic [3:0]                        m_axi_awcache_o,
  output logic [2:0]                        m_axi_awprot_o,
  output logic                              m_axi_awvalid_o,
  input  logic                              m_axi_awready_i,
  output logic [DATA_WIDTH-1:0]             m_axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           m_axi_wstrb_o,
  output logic                              m_axi_wlast_o,
  output logic                              m_axi_wvalid_o,
  input  logic                              m_axi_wready_i,
  input  logic [ID_WIDTH-1:0]               m_axi_bid_i,
  input  logic [1:0]                        m_axi_bresp_i,
  input  logic                              m_axi_bvalid_i,
  output logic                              m_axi_bready_o,
  input  logic                              m_axi_acvalid_i,
  input  logic [ADDR_WIDTH-1:0]             m_axi_acaddr_i,
  input  logic [3:0]                        m_axi_acsnoop_i,
  output logic                              m_axi_acready_o
);

  localparam int unsigned IdxW    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned WordW   = $clog2(LINE_WORDS);
  localparam int unsigned CntW    = WordW + 1;
  localparam int unsigned OffBits = line_offset_bits(LINE_WORDS, DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LineMask =
      ~((ADDR_WIDTH'(1) << OffBits) - ADDR_WIDTH'(1));
  localparam logic [2:0] SizeVal = 3'($clog2(DATA_WIDTH / 8));

  bus_state_t             state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_BITS-1:0]   wline_q, wline_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   stale_q, stale_d;
  logic                   inv_q, inv_d;
  logic                   reinv_q, reinv_d;
  logic [ADDR_WIDTH-1:0]  inv_addr_q, inv_addr_d;

  logic [NUM_CLIENTS-1:0] gnt_oh;
  logic [IdxW-1:0]        gnt_idx;
  logic                   gnt_valid;
  logic                   grant_en;
  logic                   reinv_now;
  logic                   snoop_hs;
  logic                   snoop_hit;
  logic                   unused_inputs;

  assign unused_inputs = ^{m_axi_rid_i, m_axi_rresp_i, m_axi_bid_i, m_axi_bresp_i,
                           m_axi_acsnoop_i};

  rr_arbiter #(
    .NUM_CLIENTS(NUM_CLIENTS)
  ) u_rr_arbiter (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (command_valid_i),
    .grant_en_i   (grant_en),
    .grant_o      (gnt_oh),
    .grant_idx_o  (gnt_idx),
    .grant_valid_o(gnt_valid)
  );

  // Fixed burst shape: one whole line per INCR burst.
  assign m_axi_arid_o    = ID_WIDTH'(idx_q);
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arlen_o   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize_o  = SizeVal;
  assign m_axi_arburst_o = AXI_BURST_INCR;
  assign m_axi_arlock_o  = 1'b0;
  assign m_axi_arcache_o = 4'b0;
  assign m_axi_arprot_o  = 3'b0;
  assign m_axi_awid_o    = ID_WIDTH'(idx_q);
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = 8'(LINE_WORDS - 1);
  assign m_axi_awsize_o  = SizeVal;
  assign m_axi_awburst_o = AXI_BURST_INCR;
  assign m_axi_awlock_o  = 1'b0;
  assign m_axi_awcache_o = 4'b0;
  assign m_axi_awprot_o  = 3'b0;
  assign m_axi_wstrb_o   = '1;
  assign m_axi_wdata_o   = wline_q[32'(cnt_q[WordW-1:0]) * DATA_WIDTH +: DATA_WIDTH];

  assign data_out_o        = line_q;
  assign invalidate_o      = inv_q;
  assign invalidate_addr_o = inv_addr_q;

  // The re-invalidate owns the invalidate output, so snoops are held off around it.
  assign reinv_now       = (state_q == StDone) && stale_q;
  assign m_axi_acready_o = !(reinv_now || reinv_q);
  assign snoop_hs        = m_axi_acvalid_i && m_axi_acready_o;
  assign snoop_hit       = snoop_hs && ((state_q == StRdAddr) || (state_q == StRdData)) &&
                           ((m_axi_acaddr_i & LineMask) == addr_q);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    addr_d          = addr_q;
    wline_d         = wline_q;
    line_d          = line_q;
    cnt_d           = cnt_q;
    stale_d         = stale_q;
    grant_en        = 1'b0;
    bus_valid_o     = '0;
    m_axi_arvalid_o = 1'b0;
    m_axi_rready_o  = 1'b0;
    m_axi_awvalid_o = 1'b0;
    m_axi_wvalid_o  = 1'b0;
    m_axi_wlast_o   = 1'b0;
    m_axi_bready_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          grant_en = 1'b1;
          idx_d    = gnt_idx;
          addr_d   = command_addr_i[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH] & LineMask;
          wline_d  = data_in_i[32'(gnt_idx) * LINE_BITS +: LINE_BITS];
          cnt_d    = '0;
          stale_d  = 1'b0;
          state_d  = |(gnt_oh & command_store_i) ? StWrAddr : StRdAddr;
        end
      end
      StRdAddr: begin
        m_axi_arvalid_o = 1'b1;
        if (m_axi_arready_i) state_d = StRdData;
      end
      StRdData: begin
        m_axi_rready_o = 1'b1;
        if (m_axi_rvalid_i) begin
          // Beats past the end of the line are dropped; cnt saturates at LINE_WORDS.
          if (!cnt_q[WordW]) begin
            line_d[32'(cnt_q[WordW-1:0]) * DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata_i;
            cnt_d = cnt_q + CntW'(1);
          end
          if (m_axi_rlast_i) state_d = StDone;
        end
      end
      StWrAddr: begin
        m_axi_awvalid_o = 1'b1;
        if (m_axi_awready_i) state_d = StWrData;
      end
      StWrData: begin
        m_axi_wvalid_o = 1'b1;
        m_axi_wlast_o  = (cnt_q == CntW'(LINE_WORDS - 1));
        if (m_axi_wready_i) begin
          cnt_d = cnt_q + CntW'(1);
          if (m_axi_wlast_o) state_d = StWrResp;
        end
      end
      StWrResp: begin
        m_axi_bready_o = 1'b1;
        if (m_axi_bvalid_i) state_d = StDone;
      end
      StDone: begin
        bus_valid_o[idx_q] = 1'b1;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase

    inv_d      = 1'b0;
    reinv_d    = 1'b0;
    inv_addr_d = inv_addr_q;
    if (reinv_now) begin
      inv_d      = 1'b1;
      reinv_d    = 1'b1;
      inv_addr_d = addr_q;
      stale_d    = 1'b0;
    end else if (snoop_hs) begin
      inv_d      = 1'b1;
      inv_addr_d = m_axi_acaddr_i;
    end
    if (snoop_hit) stale_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      addr_q     <= '0;
      wline_q    <= '0;
      line_q     <= '0;
      cnt_q      <= '0;
      stale_q    <= 1'b0;
      inv_q      <= 1'b0;
      reinv_q    <= 1'b0;
      inv_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wline_q    <= wline_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      stale_q    <= stale_d;
      inv_q      <= inv_d;
      reinv_q    <= reinv_d;
      inv_addr_q <= inv_addr_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Randomised bench for cache_axi_arbiter: AXI slave, client and snoop stimulus
// checked against a line-level model (round-robin order, line contents, beats).
module tb_cache_axi_arbiter;

  localparam int NC = 2;
  localparam int IW = 13;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int LB = LW * DW;
  localparam logic [63:0] LINE_MASK = ~(64'(LW * DW / 8) - 64'd1);

  logic            clk, rst_n;
  logic [NC-1:0]   cmd_valid, cmd_store;
  logic [NC*AW-1:0] cmd_addr;
  logic [NC*LB-1:0] data_in;
  logic [NC-1:0]   bus_valid;
  logic [LB-1:0]   data_out;
  logic            invalidate;
  logic [AW-1:0]   invalidate_addr;
  logic [IW-1:0]   arid, awid, rid, bid;
  logic [AW-1:0]   araddr, awaddr, acaddr;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, awburst, rresp, bresp;
  logic [3:0]      arcache, awcache, acsnoop;
  logic            arlock, awlock, arvalid, arready, awvalid, awready;
  logic [DW-1:0]   rdata, wdata;
  logic [DW/8-1:0] wstrb;
  logic            rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;
  logic            acvalid, acready;

  cache_axi_arbiter #(
    .NUM_CLIENTS(NC), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .command_valid_i(cmd_valid), .command_store_i(cmd_store), .command_addr_i(cmd_addr),
    .data_in_i(data_in), .bus_valid_o(bus_valid), .data_out_o(data_out),
    .invalidate_o(invalidate), .invalidate_addr_o(invalidate_addr),
    .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen),
    .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst), .m_axi_arlock_o(arlock),
    .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot), .m_axi_arvalid_o(arvalid),
    .m_axi_arready_i(arready),
    .m_axi_rid_i(rid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
    .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen),
    .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst), .m_axi_awlock_o(awlock),
    .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot), .m_axi_awvalid_o(awvalid),
    .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
    .m_axi_acvalid_i(acvalid), .m_axi_acaddr_i(acaddr), .m_axi_acsnoop_i(acsnoop),
    .m_axi_acready_o(acready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          pend[NC];
  bit          st[NC];
  logic [63:0] maddr[NC];
  logic [63:0] wl[NC][LW];
  logic [63:0] exp_line[LW];
  int          rr_ptr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmds();
    for (int c = 0; c < NC; c++) begin
      cmd_valid[c] = pend[c];
      cmd_store[c] = st[c];
      cmd_addr[c*AW +: AW] = maddr[c];
      for (int k = 0; k < LW; k++) data_in[(c*LW + k)*DW +: DW] = wl[c][k];
    end
  endtask

  task automatic new_request(input int c, input bit store);
    pend[c]  = 1'b1;
    st[c]    = store;
    maddr[c] = {$urandom, $urandom};
    for (int k = 0; k < LW; k++) wl[c][k] = {$urandom, $urandom};
  endtask

  // First pending client after the last winner, wrapping.
  function automatic int model_grant();
    for (int i = 1; i <= NC; i++) begin
      if (pend[(rr_ptr + i) % NC]) begin
        rr_ptr = (rr_ptr + i) % NC;
        return rr_ptr;
      end
    end
    return 0;
  endfunction

  task automatic check_line(input string tag);
    for (int k = 0; k < LW; k++) check_eq(tag, data_out[k*DW +: DW], exp_line[k]);
  endtask

  task automatic serve_read(input int w, input int nb, input bit directed, input int snoop_mode,
                            input logic [63:0] snoop_addr, input int abort_at,
                            output bit aborted);
    int n = 0;
    logic [63:0] beat;
    aborted = 1'b0;
    while (arvalid !== 1'b1 && n < 40) begin tick(); n++; end
    check_eq("ar_valid", 64'(arvalid), 64'd1);
    if (arvalid !== 1'b1) return;
    check_eq("arid", 64'(arid), 64'(w));
    check_eq("araddr", araddr, maddr[w] & LINE_MASK);
    check_eq("arlen", 64'(arlen), 64'(LW - 1));
    check_eq("arsize", 64'(arsize), 64'd3);
    check_eq("arburst", 64'(arburst), 64'd1);
    repeat ($urandom_range(0, 2)) tick();
    arready = 1'b1; tick(); arready = 1'b0;
    check_eq("rready", 64'(rready), 64'd1);
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (b == abort_at) begin aborted = 1'b1; return; end
      beat   = directed ? 64'(b) : {$urandom, $urandom};
      rvalid = 1'b1; rdata = beat; rlast = (b == nb - 1);
      if (b == 1 && snoop_mode != 0) begin
        check_eq("acready_fill", 64'(acready), 64'd1);
        acvalid = 1'b1; acaddr = snoop_addr;
      end
      tick();
      if (b < LW) exp_line[b] = beat;
      rvalid = 1'b0; rlast = 1'b0;
      if (acvalid) begin
        acvalid = 1'b0;
        check_eq("snoop_inv", 64'(invalidate), 64'd1);
        check_eq("snoop_inv_addr", invalidate_addr, snoop_addr);
      end
    end
    check_eq("rd_bus_valid", 64'(bus_valid), 64'd1 << w);
    check_line("rd_line");
    pend[w] = 1'b0; drive_cmds(); tick();
    check_eq("rd_bus_valid_off", 64'(bus_valid), 64'd0);
    check_eq("reinv", 64'(invalidate), 64'(snoop_mode == 1));
    if (snoop_mode == 1) begin
      check_eq("reinv_addr", invalidate_addr, maddr[w] & LINE_MASK);
      check_eq("reinv_acready", 64'(acready), 64'd0);
    end
    check_eq("rd_line_held", data_out[0 +: DW], exp_line[0]);
  endtask

  task automatic serve_write(input int w);
    int n = 0;
    while (awvalid !== 1'b1 && n < 40) begin tick(); n++; end
    check_eq("aw_valid", 64'(awvalid), 64'd1);
    if (awvalid !== 1'b1) return;
    check_eq("awid", 64'(awid), 64'(w));
    check_eq("awaddr", awaddr, maddr[w] & LINE_MASK);
    check_eq("awlen", 64'(awlen), 64'(LW - 1));
    check_eq("awsize", 64'(awsize), 64'd3);
    check_eq("awburst", 64'(awburst), 64'd1);
    check_eq("wstrb", 64'(wstrb), 64'hFF);
    repeat ($urandom_range(0, 2)) tick();
    awready = 1'b1; tick(); awready = 1'b0;
    for (int k = 0; k < LW; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      check_eq("wvalid", 64'(wvalid), 64'd1);
      check_eq("wdata", wdata, wl[w][k]);
      check_eq("wlast", 64'(wlast), 64'(k == LW - 1));
      wready = 1'b1; tick(); wready = 1'b0;
    end
    check_eq("bready", 64'(bready), 64'd1);
    repeat ($urandom_range(0, 3)) begin
      check_eq("wr_bus_valid_early", 64'(bus_valid), 64'd0);
      tick();
    end
    check_eq("wr_bus_valid_early", 64'(bus_valid), 64'd0);
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    check_eq("wr_bus_valid", 64'(bus_valid), 64'd1 << w);
    pend[w] = 1'b0; drive_cmds(); tick();
    check_eq("wr_bus_valid_off", 64'(bus_valid), 64'd0);
  endtask

  task automatic run_txn(input int w, input int nb, input bit directed, input int snoop_mode,
                         input logic [63:0] snoop_addr);
    bit ab;
    if (st[w]) serve_write(w);
    else serve_read(w, nb, directed, snoop_mode, snoop_addr, -1, ab);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int nb;
    int sm;
    bit ab;
    logic [63:0] sa;
    rst_n = 1'b1;
    {arready, rvalid, rlast, awready, wready, bvalid, acvalid} = '0;
    rid = '0; bid = '0; rresp = '0; bresp = '0; acsnoop = '0; rdata = '0; acaddr = '0;
    for (int c = 0; c < NC; c++) begin
      pend[c] = 1'b0; st[c] = 1'b0; maddr[c] = '0;
      for (int k = 0; k < LW; k++) wl[c][k] = '0;
    end
    for (int k = 0; k < LW; k++) exp_line[k] = '0;
    rr_ptr = NC - 1;
    drive_cmds();
    #1 rst_n = 1'b0;
    repeat (2) tick();

    check_eq("rst_arvalid", 64'(arvalid), 64'd0);
    check_eq("rst_awvalid", 64'(awvalid), 64'd0);
    check_eq("rst_wvalid", 64'(wvalid), 64'd0);
    check_eq("rst_rready", 64'(rready), 64'd0);
    check_eq("rst_bready", 64'(bready), 64'd0);
    check_eq("rst_bus_valid", 64'(bus_valid), 64'd0);
    check_eq("rst_invalidate", 64'(invalidate), 64'd0);
    check_eq("rst_data_out", 64'(|data_out), 64'd0);
    rst_n = 1'b1;
    tick();

    // Idle snoop
    acaddr = 64'h8000; acvalid = 1'b1;
    check_eq("idle_acready", 64'(acready), 64'd1);
    tick(); acvalid = 1'b0;
    check_eq("idle_inv", 64'(invalidate), 64'd1);
    check_eq("idle_inv_addr", invalidate_addr, 64'h8000);
    tick();
    check_eq("idle_inv_off", 64'(invalidate), 64'd0);

    // Directed read: client 0, 0x1234, word k = k
    pend[0] = 1'b1; st[0] = 1'b0; maddr[0] = 64'h1234; drive_cmds();
    w = model_grant();
    run_txn(w, LW, 1'b1, 0, '0);

    // Directed write: client 1, word k = 0xA0 + k
    new_request(1, 1'b1);
    for (int k = 0; k < LW; k++) wl[1][k] = 64'hA0 + 64'(k);
    drive_cmds();
    w = model_grant();
    run_txn(w, LW, 1'b0, 0, '0);

    // Stale fill: snoop 0x1240 during the 0x1200 fill
    pend[0] = 1'b1; st[0] = 1'b0; maddr[0] = 64'h1200; drive_cmds();
    w = model_grant();
    run_txn(w, LW, 1'b0, 1, 64'h1240);

    // Both clients requesting continuously
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < NC; c++) if (!pend[c]) new_request(c, 1'(($urandom_range(0, 1))));
      drive_cmds();
      w = model_grant();
      run_txn(w, LW, 1'b0, 0, '0);
    end

    // Random mix: early rlast, extra beats, matching and non-matching snoops
    for (int t = 0; t < 24; t++) begin
      for (int c = 0; c < NC; c++)
        if (!pend[c] && $urandom_range(0, 3) != 0) new_request(c, 1'(($urandom_range(0, 1))));
      if (!pend[0] && !pend[1]) new_request($urandom_range(0, NC - 1), 1'b0);
      drive_cmds();
      w = model_grant();
      case ($urandom_range(0, 4))
        0: nb = 12;
        1: nb = 19;
        default: nb = LW;
      endcase
      sm = $urandom_range(0, 2);
      sa = (sm == 1) ? ((maddr[w] & LINE_MASK) | 64'($urandom_range(0, 127)))
                     : ((maddr[w] & LINE_MASK) + 64'h80);
      run_txn(w, nb, 1'b0, sm, sa);
    end

    // Reset mid-fill at beat 5, then client 0 must be granted again
    for (int c = 0; c < NC; c++) if (!pend[c]) new_request(c, 1'b0);
    for (int c = 0; c < NC; c++) st[c] = 1'b0;
    drive_cmds();
    w = model_grant();
    serve_read(w, LW, 1'b0, 0, '0, 5, ab);
    check_eq("abort_reached", 64'(ab), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rready", 64'(rready), 64'd0);
    check_eq("mid_rst_arvalid", 64'(arvalid), 64'd0);
    check_eq("mid_rst_bus_valid", 64'(bus_valid), 64'd0);
    check_eq("mid_rst_inv", 64'(invalidate), 64'd0);
    check_eq("mid_rst_data_out", 64'(|data_out), 64'd0);
    rr_ptr = NC - 1;
    for (int k = 0; k < LW; k++) exp_line[k] = '0;
    tick();
    rst_n = 1'b1;
    w = model_grant();
    run_txn(w, LW, 1'b0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_axi_arbiter.md
Name: cache_axi_arbiter

Overview:
- Parametrised N-client line-fill/write-back engine between the L1 caches and the AXI master port. It replaces the fixed two-client bus used by the pipeline top.
- Arbitrates per-line read or write requests round-robin and issues AXI INCR bursts of LINE_WORDS beats.
- Assembles and serialises whole cache lines.
- Forwards AC snoops as invalidate pulses, including a stale-fill re-invalidate.

Parameters:
NUM_CLIENTS, 2, number of cache clients (index 0 = highest tie priority after reset)
ID_WIDTH, 13, AXI ID width; IDs carry the client index, zero-extended
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, AXI beat width
LINE_WORDS, 16, beats per cache line (power of 2, 2..256); LINE_BITS = LINE_WORDS*DATA_WIDTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
command_valid  in  NUM_CLIENTS  per-client request; held until that client's bus_valid
command_store  in  NUM_CLIENTS  1 = write line, 0 = read line
command_addr  in  NUM_CLIENTS*ADDR_WIDTH  packed request addresses, client i at slice i
data_in  in  NUM_CLIENTS*LINE_BITS  packed write-back lines, word 0 in LSBs
bus_valid  out  NUM_CLIENTS  one-cycle completion pulse to the granted client
data_out  out  LINE_BITS  assembled read line; valid while bus_valid pulses and held after
invalidate  out  1  one-cycle snoop invalidate pulse
invalidate_addr  out  ADDR_WIDTH  address accompanying invalidate
m_axi_ar*  AR channel: arid, araddr, arlen[8], arsize[3], arburst[2], arlock, arcache[4], arprot[3], arvalid out; arready in
m_axi_r*  R channel: rid, rdata, rresp, rlast, rvalid in; rready out
m_axi_aw*/w*/b*  AW/W/B channels, same widths as the AR/R set; wstrb is DATA_WIDTH/8
m_axi_ac*  acvalid in, acaddr[ADDR_WIDTH] in, acsnoop[4] in, acready out

Behaviour:
- Reset (reset low, async): state IDLE; rr pointer = NUM_CLIENTS-1 so client 0 wins first; all valids, bus_valid, invalidate, rready, bready low; data_out 0; beat counter 0.
- Fixed fields: len = LINE_WORDS-1; size = log2(DATA_WIDTH/8); burst = INCR (2'b01); lock/cache/prot = 0; wstrb all ones.
- Burst address: command_addr with the low log2(LINE_WORDS*DATA_WIDTH/8) bits cleared.
- FSM IDLE: if any command_valid, grant the first requester after the rr pointer (wrapping) and update the pointer. Latch index, address, store flag and write line. Go to RD_ADDR or WR_ADDR. Grant takes 1 cycle.
- RD_ADDR: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. Each rvalid beat writes data_out word[cnt] and increments cnt.
  - Beats with cnt >= LINE_WORDS are discarded.
  - rlast ends the burst and goes to DONE. On an early rlast, the unfilled words keep their old values.
- WR_ADDR: awvalid=1 until awready.
- WR_DATA: then wvalid=1 with wdata = latched word[cnt]; advance on wready. wlast=1 when cnt==LINE_WORDS-1; after its handshake go to WR_RESP.
- WR_RESP: bready=1; on bvalid go to DONE.
- DONE: bus_valid[idx]=1 for exactly one cycle, then IDLE.
  - Clients must drop command_valid on the edge they see the pulse. A still-high valid in IDLE is a new request.
- rresp/bresp are ignored in this generation; completion always pulses.
- Snoop: acready=1 except while a re-invalidate is pending.
  - On an acvalid&&acready handshake, the next cycle drives invalidate=1 with invalidate_addr=acaddr.
- Stale fill: if a handshaken snoop line matches the in-flight read line (RD_ADDR..DONE), set stale.
  - One cycle after DONE, re-pulse invalidate with that line address and clear stale.
  - acready stays low in that cycle; this takes precedence over a new snoop.
- Simultaneous request and completion: a request is never granted in DONE; arbitration happens only in IDLE.
- Reset asserted mid-burst aborts immediately. There is no AXI clean-up; the slave is assumed reset together with the core.

Decomposition:
- Package cache_bus_pkg:
  - bus_state_t enum (IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE).
  - Constants AXI_BURST_INCR=2'b01 and a line_offset_bits function.
- Sub-module rr_arbiter:
  - NUM_CLIENTS request vector, pointer register, one-hot grant plus index.
  - Advances only on a grant_en strobe.

Test Plan:
- Single read, client 0, addr 0x1234 with LINE_WORDS=16: araddr=0x1200, arlen=15, arsize=3; beats 0..15 give data_out word k = k; bus_valid=2'b01 for one cycle.
- Write, client 1, data_in word k=0xA0+k: awid=1, 16 W beats with wdata in order and wlast only on beat 15; bus_valid=2'b10 only after bvalid.
- Both clients requesting continuously: grants alternate 0,1,0,1; AXI IDs match.
- Snoop during idle, acaddr=0x8000: invalidate pulses one cycle later with invalidate_addr=0x8000.
- Snoop 0x1240 during an 0x1200 fill: invalidate pulses immediately and again the cycle after DONE; acready is low that cycle.
- Reset pulled low mid-RD_DATA at beat 5: all outputs return to reset values asynchronously; after release, client 0 is re-granted and the full burst completes.
